// File: rtl/darkroom_pkg.sv
// Shared constants and types for the DarkRoom SPI frame receiver.
package darkroom_pkg;

  localparam int FRAME_WORDS = 8;
  localparam int WORD_WIDTH  = 32;

  localparam logic [3:0] ADDR_STATUS = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input, with rise/fall pulses
// derived from the synchronized value (one clock wide each).
module sync_edge_detect #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the raw input through the chain and remember the last synced value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], din};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign dout = r_sync[STAGES-1];
  assign rise = r_sync[STAGES-1] & ~r_prev;
  assign fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/darkroom_spi_receiver.sv
// DarkRoom SPI slave (mode 0): receives fixed-length frames, commits only
// frames of exactly FRAME_BITS bits, and exposes the committed frame plus a
// status word on an Avalon-MM read slave.
// Optional build macro: DARKROOM_SPI_RX_SNAPSHOT_EN -- reading word 0 also
// snapshots the whole frame so words 1..N-1 are read from the same frame.
module darkroom_spi_receiver
  import darkroom_pkg::*;
#(
  parameter int FRAME_BITS  = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sck_i,
  input  logic        ss_n_i,
  input  logic        mosi_i,
  input  logic [3:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        frame_valid_o,
  output logic        error_o
);

  localparam int NWORDS = FRAME_BITS / WORD_WIDTH;
  localparam int CNT_W  = $clog2(FRAME_BITS + 2);
  localparam int IDX_W  = $clog2(FRAME_BITS);
  localparam int WSEL_W = $clog2(NWORDS);
  localparam logic [CNT_W-1:0] CNT_FULL       = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT        = CNT_W'(FRAME_BITS + 1);
  localparam logic [3:0]       ADDR_LAST_WORD = 4'(NWORDS - 1);

  logic w_sck_rise, w_sck_fall_unused, w_sck_unused;
  logic w_ss_rise, w_ss_fall, w_ss_unused;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clock(clock), .reset(reset), .din(sck_i),
    .dout(w_sck_unused), .rise(w_sck_rise), .fall(w_sck_fall_unused)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clock(clock), .reset(reset), .din(ss_n_i),
    .dout(w_ss_unused), .rise(w_ss_rise), .fall(w_ss_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset), .din(mosi_i),
    .dout(w_mosi), .rise(w_mosi_rise_unused), .fall(w_mosi_fall_unused)
  );

  rx_state_e                    r_state;
  logic [CNT_W-1:0]             r_cnt;
  logic [FRAME_BITS-1:0]        r_shift;
  logic [NWORDS-1:0][WORD_WIDTH-1:0] r_buf;
  logic [15:0]                  r_frame_count;
  logic                         r_frame_valid;
  logic                         r_error;
  logic                         r_rvalid;
  logic [31:0]                  r_readdata;
  logic [31:0]                  w_rdata;
  logic [IDX_W-1:0]             w_bit_idx;
  logic [WSEL_W-1:0]            w_wsel;
  logic                         w_rd_accept;
  logic                         w_status_rd;
  logic                         w_commit_bad;

  // Byte k of the stream fills frame bits [8k+7:8k] MSB first, so the bit
  // position is the counter with its low three bits inverted.
  assign w_bit_idx    = r_cnt[IDX_W-1:0] ^ IDX_W'(3'b111);
  assign w_wsel       = address[WSEL_W-1:0];
  assign w_rd_accept  = read & ~r_rvalid;
  assign w_status_rd  = w_rd_accept && (address == ADDR_STATUS);
  assign w_commit_bad = (r_state == ST_COMMIT) && (r_cnt != CNT_FULL);

  // Receive FSM: frame capture, length check and commit of good frames.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_buf         <= '0;
      r_frame_count <= 16'd0;
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ss_fall) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_shift <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_ss_rise) begin
            r_state <= ST_COMMIT;
          end else if (w_sck_rise) begin
            if (r_cnt < CNT_FULL) begin
              r_shift[w_bit_idx] <= w_mosi;
            end
            if (r_cnt != CNT_SAT) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_COMMIT: begin
          if (r_cnt == CNT_FULL) begin
            r_buf         <= r_shift;
            r_frame_valid <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
          end
          // A new select right behind the previous frame must not be lost.
          if (w_ss_fall) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_shift <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky frame error: a new bad frame wins over a status-read clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if (w_commit_bad) begin
      r_error <= 1'b1;
    end else if (w_status_rd) begin
      r_error <= 1'b0;
    end
  end

`ifdef DARKROOM_SPI_RX_SNAPSHOT_EN
  logic [NWORDS-1:0][WORD_WIDTH-1:0] r_snap;

  // Word 0 read freezes the whole committed frame for the following words.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_snap <= '0;
    end else if (w_rd_accept && (address == 4'd0)) begin
      r_snap <= r_buf;
    end
  end
`endif

  // Read data selection for the address presented this cycle.
  always_comb begin
    w_rdata = 32'h0000_0000;
    if (address == ADDR_STATUS) begin
      w_rdata = {r_error, 15'h0000, r_frame_count};
    end else if (address <= ADDR_LAST_WORD) begin
`ifdef DARKROOM_SPI_RX_SNAPSHOT_EN
      if (address == 4'd0) begin
        w_rdata = r_buf[0];
      end else begin
        w_rdata = r_snap[w_wsel];
      end
`else
      w_rdata = r_buf[w_wsel];
`endif
    end else begin
      w_rdata = 32'h0000_0000;
    end
  end

  // Avalon read: one wait cycle, then registered data with waitrequest low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rvalid   <= 1'b0;
      r_readdata <= 32'h0000_0000;
    end else begin
      r_rvalid <= w_rd_accept;
      if (w_rd_accept) begin
        r_readdata <= w_rdata;
      end
    end
  end

  assign readdata      = r_readdata;
  assign waitrequest   = w_rd_accept;
  assign frame_valid_o = r_frame_valid;
  assign error_o       = r_error;

endmodule

// File: tb/tb_darkroom_spi_receiver.sv
// Directed self-checking bench for darkroom_spi_receiver.
module tb_darkroom_spi_receiver;

  logic        clock = 1'b0;
  logic        reset;
  logic        sck_i;
  logic        ss_n_i;
  logic        mosi_i;
  logic [3:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        frame_valid_o;
  logic        error_o;

  int n_checks = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;

  always #5 clock = ~clock;

  darkroom_spi_receiver #(.FRAME_BITS(256), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .sck_i(sck_i), .ss_n_i(ss_n_i),
    .mosi_i(mosi_i), .address(address), .read(read), .readdata(readdata),
    .waitrequest(waitrequest), .frame_valid_o(frame_valid_o), .error_o(error_o)
  );

  // Count frame_valid pulses away from the active edge.
  always @(negedge clock) begin
    if (frame_valid_o === 1'b1) fv_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [255:0] mk_frame(input logic [31:0] base);
    logic [255:0] f;
    for (int n = 0; n < 8; n++) f[32*n +: 32] = base + n;
    return f;
  endfunction

  // Select low and clock out nbits; bits past 256 are filler ones. ss_n stays low.
  task automatic send_bits(input logic [255:0] f, input int nbits);
    int k;
    int p;
    ss_n_i = 1'b0;
    tick(3);
    for (int j = 0; j < nbits; j++) begin
      k = j / 8;
      p = j % 8;
      mosi_i = (j < 256) ? f[8*k + 7 - p] : 1'b1;
      tick(3);
      sck_i = 1'b1;
      tick(3);
      sck_i = 1'b0;
    end
    tick(3);
  endtask

  task automatic end_frame();
    ss_n_i = 1'b1;
    tick(10);
  endtask

  task automatic av_read(input logic [3:0] a, output logic [31:0] d);
    int waits;
    address = a;
    read    = 1'b1;
    #1;
    check("wait_first", {31'b0, waitrequest}, 32'd1);
    waits = 0;
    do begin
      tick(1);
      waits++;
    end while (waitrequest && waits < 4);
    check("rd_latency", waits, 32'd1);
    d    = readdata;
    read = 1'b0;
    tick(1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int fv0;

    reset = 1'b1; sck_i = 1'b0; ss_n_i = 1'b1; mosi_i = 1'b0;
    read = 1'b0; address = 4'd0;
    tick(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_wait", {31'b0, waitrequest}, 32'd0);
    check("rst_fv", {31'b0, frame_valid_o}, 32'd0);
    check("rst_err", {31'b0, error_o}, 32'd0);
    reset = 1'b0;
    tick(3);

    // Good frame A, with pulse timing measured from the ss_n rising edge.
    fv0 = fv_cnt;
    send_bits(mk_frame(32'h1000_0000), 256);
    ss_n_i = 1'b1;
    repeat (4) @(negedge clock);
    check("fv_early", {31'b0, frame_valid_o}, 32'd0);
    @(negedge clock);
    check("fv_on_time", {31'b0, frame_valid_o}, 32'd1);
    @(negedge clock);
    check("fv_one_cycle", {31'b0, frame_valid_o}, 32'd0);
    tick(5);
    check("fv_pulses_A", fv_cnt - fv0, 32'd1);
    for (int a = 0; a < 8; a++) begin
      av_read(4'(a), d);
      check("word_A", d, 32'h1000_0000 + a);
    end
    av_read(4'd8, d);
    check("status_A", d, 32'h0000_0001);

    // Short frame: dropped, error flagged, cleared by a status read.
    fv0 = fv_cnt;
    send_bits(mk_frame(32'h2000_0000), 248);
    end_frame();
    check("fv_pulses_short", fv_cnt - fv0, 32'd0);
    check("err_short", {31'b0, error_o}, 32'd1);
    av_read(4'd0, d);
    check("word0_after_short", d, 32'h1000_0000);
    av_read(4'd8, d);
    check("status_short", d, 32'h8000_0001);
    av_read(4'd8, d);
    check("status_cleared", d, 32'h0000_0001);
    check("err_cleared", {31'b0, error_o}, 32'd0);

    // Long frame: dropped, error flagged, count unchanged.
    fv0 = fv_cnt;
    send_bits(mk_frame(32'h2000_0000), 264);
    end_frame();
    check("fv_pulses_long", fv_cnt - fv0, 32'd0);
    check("err_long", {31'b0, error_o}, 32'd1);
    av_read(4'd7, d);
    check("word7_after_long", d, 32'h1000_0007);
    av_read(4'd8, d);
    check("status_long", d, 32'h8000_0001);
    av_read(4'd8, d);
    check("status_long_clr", d, 32'h0000_0001);

    // Reset in the middle of a frame, then a full frame.
    send_bits(mk_frame(32'h3000_0000), 100);
    reset = 1'b1; ss_n_i = 1'b1; sck_i = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(3);
    check("err_after_rst", {31'b0, error_o}, 32'd0);
    av_read(4'd8, d);
    check("status_after_rst", d, 32'h0000_0000);
    av_read(4'd1, d);
    check("word1_after_rst", d, 32'h0000_0000);
    fv0 = fv_cnt;
    send_bits(mk_frame(32'h3000_0000), 256);
    end_frame();
    check("fv_pulses_C", fv_cnt - fv0, 32'd1);
    av_read(4'd8, d);
    check("status_C", d, 32'h0000_0001);
    av_read(4'd2, d);
    check("word2_C", d, 32'h3000_0002);

    // Read word 3 in the commit cycle of frame D: old data, then new.
    send_bits(mk_frame(32'hD000_0000), 256);
    ss_n_i = 1'b1;
    tick(3);
    av_read(4'd3, d);
    check("word3_commit_cycle", d, 32'h3000_0003);
    tick(4);
    av_read(4'd3, d);
    check("word3_after_commit", d, 32'hD000_0003);
    av_read(4'd8, d);
    check("status_D", d, 32'h0000_0002);

    // Unmapped addresses.
    av_read(4'd9, d);
    check("addr9", d, 32'h0);
    av_read(4'd15, d);
    check("addr15", d, 32'h0);

    // Word 0, new frame, then word 5: snapshot build keeps the old frame.
    av_read(4'd0, d);
    check("word0_D", d, 32'hD000_0000);
    send_bits(mk_frame(32'hE000_0000), 256);
    end_frame();
    av_read(4'd5, d);
`ifdef DARKROOM_SPI_RX_SNAPSHOT_EN
    check("word5_snapshot", d, 32'hD000_0005);
`else
    check("word5_direct", d, 32'hE000_0005);
`endif
    av_read(4'd0, d);
    check("word0_E", d, 32'hE000_0000);
    av_read(4'd5, d);
    check("word5_E", d, 32'hE000_0005);
    av_read(4'd8, d);
    check("status_E", d, 32'h0000_0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/darkroom_spi_receiver.md
# darkroom_spi_receiver

SPI slave that receives DarkRoom sensor frames (256 bits = 8 × 32-bit decoded sensor words) from the DarkRoom SPI master and exposes the last complete frame on an Avalon-MM read slave. Sits on the receiving FPGA/SoC side of the SPI link and replaces the ESP8266 as frame consumer. Incomplete or overlong frames are dropped and flagged, never partially committed.

## Interface
Parameters:
- FRAME_BITS, 256, bits per frame; fixed multiple of 32.
- SYNC_STAGES, 2, synchronizer flops on sck_i, ss_n_i, mosi_i.

Ports:
- clock  in  1  system clock; one clock for the whole block.
- reset  in  1  asynchronous, active-high reset.
- sck_i  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- ss_n_i  in  1  SPI slave select, active low.
- mosi_i  in  1  SPI data in.
- address  in  4  Avalon word address: 0–7 frame words, 8 status.
- read  in  1  Avalon read strobe.
- readdata  out  32  Avalon read data.
- waitrequest  out  1  Avalon wait.
- frame_valid_o  out  1  one-cycle pulse per committed frame.
- error_o  out  1  sticky frame error.

## Operation
- Inputs pass through SYNC_STAGES flops; sck rising edge and ss_n rising/falling edges detected on synchronized signals.
- States: IDLE → SHIFT on ss_n fall (bit counter cleared, shift register cleared). SHIFT: each sck rise samples synchronized mosi, bit counter +1, saturating at FRAME_BITS+1. SHIFT → COMMIT on ss_n rise. COMMIT → IDLE after one cycle.
- Bit ordering: byte k of transmission holds frame bits [8k+7:8k], MSB first within byte. Word n = frame bits [32n+31:32n].
- COMMIT: if counter == FRAME_BITS, copy shift register to committed buffer, pulse frame_valid_o, frame_count +1 (16-bit, wraps 0xFFFF→0). Otherwise (short or long frame) buffer untouched, error_o set, no pulse.
- Status word (address 8): {error_o, 15'b0, frame_count[15:0]}. Reading status clears error_o the following cycle; a simultaneous new error wins (stays set).
- Addresses 9–15 return 0.
- sck edges while ss_n high are ignored. ss_n rise in IDLE ignored.
- Reset mid-frame: shift register, counter, buffer, frame_count, error_o all cleared; state IDLE.

## Timing
- Reset values: readdata 0, waitrequest 0, frame_valid_o 0, error_o 0.
- Avalon read: read high in cycle N → waitrequest 1 in N; readdata valid and waitrequest 0 in N+1; master holds address/read until waitrequest low. Back-to-back reads each take two cycles.
- waitrequest is high only while read is asserted and data not yet returned.
- readdata samples committed buffer in cycle N; commit in the same cycle → read returns the previous frame.
- frame_valid_o pulses SYNC_STAGES+2 clocks after the ss_n_i rising edge.
- sck_i frequency ≤ clock/4; each sck high and low phase ≥ 2 clocks.

## Configuration
- DARKROOM_SPI_RX_SNAPSHOT_EN: defined → reading address 0 also copies all 8 committed words into a snapshot register; addresses 1–7 then read the snapshot, guaranteeing all words come from one frame. Not defined → addresses 0–7 read the committed buffer directly (words may span frames).

## Structure
- Package darkroom_pkg: FRAME_WORDS=8, WORD_WIDTH=32, ADDR_STATUS=8, receiver state enum (IDLE, SHIFT, COMMIT).
- Sub-module sync_edge_detect: SYNC_STAGES-flop synchronizer with rise/fall pulse outputs; three instances (sck, ss_n, mosi without edge outputs).

## Test plan
- One 256-bit frame, word n = 0x1000_0000+n → frame_valid_o pulses once; reads of address 0–7 return 0x1000_0000…0x1000_0007; status = 0x0000_0001.
- Frame of 248 bits → no frame_valid_o, buffer unchanged, status bit 31 = 1; reading status then again → second read bit 31 = 0.
- Frame of 264 bits → error_o set, buffer unchanged, frame_count unchanged.
- Assert reset at bit 100 of a frame, then send a full frame → only the full frame commits, frame_count = 1.
- Read address 3 in the same cycle as commit of a new frame → returns old word; next read returns new word.
- With SNAPSHOT_EN: read address 0, commit new frame, read address 5 → address 5 returns old-frame word 5.
